// File: rtl/snitch_icache_pkg.sv
// Shared types and constants for the instruction-cache data-memory controller.
//
// Contents:
//   config_t                 cache geometry (sets, lines per set, line width, line index width)
//   DEFAULT_CFG              two sets of 128 lines of 256 bits
//   STARVE_LIMIT_DEFAULT     stalled lookup cycles tolerated while refill holds priority
//   data_ctrl_state_e        controller FSM states
//   idx_width()              index width helper that never returns zero
package snitch_icache_pkg;

   typedef struct packed {
      logic [31:0] SET_COUNT;
      logic [31:0] LINE_COUNT;
      logic [31:0] LINE_WIDTH;
      logic [31:0] COUNT_ALIGN;
   } config_t;

   localparam config_t DEFAULT_CFG = '{
      SET_COUNT:   32'd2,
      LINE_COUNT:  32'd128,
      LINE_WIDTH:  32'd256,
      COUNT_ALIGN: 32'd7
   };

   localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } data_ctrl_state_e;

   // A single set or a limit of zero still needs a one-bit index.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/snitch_icache_data_ctrl.sv
// Data-memory controller for the instruction cache. Sits between the lookup
// and refill stages and the data SRAM: zeroes every line after reset or flush,
// then arbitrates one access per cycle between refill writes and lookup reads,
// with a starvation guard that eventually lets a blocked lookup through.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   INIT  | sweep: write zero to line r_cnt in all sets, one line/cycle
//   RUN   | serve refill (priority) and lookup requests, one per cycle
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   flush_i                      request to re-zero all lines
//   busy_o                       sweep in progress
//   lk_valid_i/lk_ready_o        lookup read handshake, lk_addr_i line index
//   lk_rvalid_o/lk_rdata_o       lookup response, all sets, one cycle after grant
//   rf_valid_i/rf_ready_o        refill write handshake
//   rf_addr_i/rf_set_i/rf_data_i refill line index, target set, line data
//   ram_*_o / ram_rdata_i        data-memory port (read data one cycle after enable)
module snitch_icache_data_ctrl
   import snitch_icache_pkg::*;
#(
   parameter config_t     CFG          = DEFAULT_CFG,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic                                             clk_i,
   input  logic                                             rst_i,
   input  logic                                             flush_i,
   output logic                                             busy_o,

   input  logic                                             lk_valid_i,
   output logic                                             lk_ready_o,
   input  logic [CFG.COUNT_ALIGN-1:0]                       lk_addr_i,
   output logic                                             lk_rvalid_o,
   output logic [CFG.SET_COUNT-1:0][CFG.LINE_WIDTH-1:0]     lk_rdata_o,

   input  logic                                             rf_valid_i,
   output logic                                             rf_ready_o,
   input  logic [CFG.COUNT_ALIGN-1:0]                       rf_addr_i,
   input  logic [idx_width(CFG.SET_COUNT)-1:0]              rf_set_i,
   input  logic [CFG.LINE_WIDTH-1:0]                        rf_data_i,

   output logic [CFG.SET_COUNT-1:0]                         ram_enable_o,
   output logic                                             ram_write_o,
   output logic [CFG.COUNT_ALIGN-1:0]                       ram_addr_o,
   output logic [CFG.SET_COUNT-1:0][CFG.LINE_WIDTH-1:0]     ram_wdata_o,
   input  logic [CFG.SET_COUNT-1:0][CFG.LINE_WIDTH-1:0]     ram_rdata_i
);

   localparam int unsigned SC  = CFG.SET_COUNT;
   localparam int unsigned LC  = CFG.LINE_COUNT;
   localparam int unsigned LW  = CFG.LINE_WIDTH;
   localparam int unsigned CA  = CFG.COUNT_ALIGN;
   localparam int unsigned STW = idx_width(STARVE_LIMIT + 1);

   localparam logic [CA-1:0]  LAST_LINE  = CA'(LC - 1);
   localparam logic [STW-1:0] STARVE_MAX = STW'(STARVE_LIMIT);

   data_ctrl_state_e          r_state;
   logic [CA-1:0]             r_cnt;
   logic [STW-1:0]            r_starve;
   logic                      r_rvalid;
   logic                      r_write;
   logic [CA-1:0]             r_addr;
   logic [SC-1:0][LW-1:0]     r_wdata;

   logic                      w_run;
   logic                      w_starved;
   logic                      w_lk_gnt;
   logic                      w_rf_gnt;

   // Reset is synchronous, but the port must look idle for the whole cycle
   // rst_i is high, so every visible output is gated with it directly.
   assign w_run     = (r_state == ST_RUN) && !rst_i;
   assign w_starved = (r_starve == STARVE_MAX);

   // Readies are mutually exclusive whenever both sides are valid, so at
   // most one grant can occur per cycle.
   assign lk_ready_o = w_run && (!rf_valid_i || w_starved);
   assign rf_ready_o = w_run && !(lk_valid_i && w_starved);
   assign w_lk_gnt   = lk_valid_i && lk_ready_o;
   assign w_rf_gnt   = rf_valid_i && rf_ready_o;

   assign busy_o      = rst_i || (r_state == ST_INIT);
   assign lk_rvalid_o = r_rvalid && !rst_i;
   assign lk_rdata_o  = ram_rdata_i;

   // Address, write flag and write data are held from the last cycle unless
   // a new access drives them, which keeps the SRAM inputs quiet when idle.
   always_comb begin
      ram_enable_o = '0;
      ram_write_o  = r_write;
      ram_addr_o   = r_addr;
      ram_wdata_o  = r_wdata;
      if (rst_i) begin
         ram_write_o = 1'b0;
         ram_addr_o  = '0;
         ram_wdata_o = '0;
      end else if (r_state == ST_INIT) begin
         ram_enable_o = '1;
         ram_write_o  = 1'b1;
         ram_addr_o   = r_cnt;
         ram_wdata_o  = '0;
      end else if (w_rf_gnt) begin
         ram_enable_o = SC'(1) << rf_set_i;
         ram_write_o  = 1'b1;
         ram_addr_o   = rf_addr_i;
         ram_wdata_o  = {SC{rf_data_i}};
      end else if (w_lk_gnt) begin
         ram_enable_o = '1;
         ram_write_o  = 1'b0;
         ram_addr_o   = lk_addr_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= ST_INIT;
         r_cnt    <= '0;
         r_starve <= '0;
         r_rvalid <= 1'b0;
         r_write  <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_rvalid <= w_lk_gnt;
         r_write  <= ram_write_o;
         r_addr   <= ram_addr_o;
         r_wdata  <= ram_wdata_o;

         if (!lk_valid_i || w_lk_gnt) begin
            r_starve <= '0;
         end else if (!w_starved) begin
            r_starve <= r_starve + STW'(1);
         end

         // A flush lets the access granted this cycle complete; only the
         // state for the next cycle is redirected.
         if (flush_i) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
         end else if (r_state == ST_INIT) begin
            if (r_cnt == LAST_LINE) begin
               r_state <= ST_RUN;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + CA'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_snitch_icache_data_ctrl.sv
// Self-checking bench for snitch_icache_data_ctrl (2 sets x 128 lines x 256 bits).
// A behavioural model tracks sweep progress, arbitration and expected memory
// contents; a simple SRAM model sits on the data-memory port.
module tb_snitch_icache_data_ctrl;
   import snitch_icache_pkg::*;

   localparam config_t CFG = '{
      SET_COUNT:   32'd2,
      LINE_COUNT:  32'd128,
      LINE_WIDTH:  32'd256,
      COUNT_ALIGN: 32'd7
   };
   localparam int LIMIT = 4;
   localparam int LINES = 128;

   logic              clk;
   logic              rst, flush;
   logic              busy;
   logic              lk_valid, lk_ready, lk_rvalid;
   logic [6:0]        lk_addr;
   logic [1:0][255:0] lk_rdata;
   logic              rf_valid, rf_ready;
   logic [6:0]        rf_addr;
   logic [0:0]        rf_set;
   logic [255:0]      rf_data;
   logic [1:0]        ram_enable;
   logic              ram_write;
   logic [6:0]        ram_addr;
   logic [1:0][255:0] ram_wdata;
   logic [1:0][255:0] ram_rdata;

   int checks = 0;
   int errors = 0;

   snitch_icache_data_ctrl #(
      .CFG          (CFG),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_i      (flush),
      .busy_o       (busy),
      .lk_valid_i   (lk_valid),
      .lk_ready_o   (lk_ready),
      .lk_addr_i    (lk_addr),
      .lk_rvalid_o  (lk_rvalid),
      .lk_rdata_o   (lk_rdata),
      .rf_valid_i   (rf_valid),
      .rf_ready_o   (rf_ready),
      .rf_addr_i    (rf_addr),
      .rf_set_i     (rf_set),
      .rf_data_i    (rf_data),
      .ram_enable_o (ram_enable),
      .ram_write_o  (ram_write),
      .ram_addr_o   (ram_addr),
      .ram_wdata_o  (ram_wdata),
      .ram_rdata_i  (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM on the data port, contents start as garbage so the sweep matters.
   logic [255:0] mem [2][LINES];
   initial begin
      for (int s = 0; s < 2; s++)
         for (int l = 0; l < LINES; l++)
            mem[s][l] = {8{$urandom()}};
      ram_rdata = '0;
   end
   always @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (ram_enable[s]) begin
            if (ram_write) mem[s][ram_addr] <= ram_wdata[s];
            else           ram_rdata[s]     <= mem[s][ram_addr];
         end
      end
   end

   // Reference model state
   bit           m_init   = 1'b1;
   int           m_cnt    = 0;
   int           m_starve = 0;
   bit           m_pend   = 1'b0;
   logic [511:0] m_exp_rd = '0;
   logic [255:0] gold [2][LINES];
   logic         m_we     = 1'b0;
   logic [6:0]   m_addr   = '0;
   logic [511:0] m_wdata  = '0;

   // Last observed values
   bit           g_busy, g_rvalid, g_lkrdy, g_rfrdy;
   logic [511:0] g_rdata;
   byte          g_win;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit r, input bit f, input bit lkv, input logic [6:0] lka,
                       input bit rfv, input logic [6:0] rfa, input bit rfs,
                       input logic [255:0] rfd);
      bit           lk_win, rf_win, e_busy, e_rv, e_we;
      logic [1:0]   e_en;
      logic [6:0]   e_addr;
      logic [511:0] e_wd;
      @(negedge clk);
      rst = r; flush = f;
      lk_valid = lkv; lk_addr = lka;
      rf_valid = rfv; rf_addr = rfa; rf_set = rfs; rf_data = rfd;
      #1;
      lk_win = 1'b0;
      rf_win = 1'b0;
      if (!r && !m_init) begin
         if (lkv && rfv) begin
            if (m_starve == LIMIT) lk_win = 1'b1;
            else                   rf_win = 1'b1;
         end else begin
            lk_win = lkv;
            rf_win = rfv;
         end
      end
      e_busy = r || m_init;
      e_rv   = !r && m_pend;
      if (r) begin
         e_en = 2'b00; e_we = 1'b0; e_addr = '0; e_wd = '0;
      end else if (m_init) begin
         e_en = 2'b11; e_we = 1'b1; e_addr = 7'(m_cnt); e_wd = '0;
      end else if (rf_win) begin
         e_en = rfs ? 2'b10 : 2'b01; e_we = 1'b1; e_addr = rfa; e_wd = {rfd, rfd};
      end else if (lk_win) begin
         e_en = 2'b11; e_we = 1'b0; e_addr = lka; e_wd = m_wdata;
      end else begin
         e_en = 2'b00; e_we = m_we; e_addr = m_addr; e_wd = m_wdata;
      end

      chk("busy", busy, e_busy);
      chk("ram_enable", ram_enable, e_en);
      chk("ram_write", ram_write, e_we);
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_wdata", ram_wdata, e_wd);
      chk("lk_rvalid", lk_rvalid, e_rv);
      if (e_rv) chk("lk_rdata", lk_rdata, m_exp_rd);
      if (e_busy) begin
         chk("lk_ready_busy", lk_ready, 1'b0);
         chk("rf_ready_busy", rf_ready, 1'b0);
      end else begin
         chk("lk_grant", lkv && lk_ready, lk_win);
         chk("rf_grant", rfv && rf_ready, rf_win);
      end

      g_busy = busy; g_rvalid = lk_rvalid; g_rdata = lk_rdata;
      g_lkrdy = lk_ready; g_rfrdy = rf_ready;
      g_win = (ram_enable != 2'b00 && !busy) ? (ram_write ? "R" : "L") : "-";

      @(posedge clk);
      if (r) begin
         m_init = 1'b1; m_cnt = 0; m_starve = 0; m_pend = 1'b0;
      end else begin
         m_pend = lk_win;
         if (!lkv || lk_win)       m_starve = 0;
         else if (m_starve < LIMIT) m_starve++;
         if (lk_win) m_exp_rd = {gold[1][lka], gold[0][lka]};
         if (m_init) begin
            gold[0][m_cnt] = '0;
            gold[1][m_cnt] = '0;
         end else if (rf_win) begin
            gold[rfs][rfa] = rfd;
         end
         if (f) begin
            m_init = 1'b1; m_cnt = 0;
         end else if (m_init) begin
            if (m_cnt == LINES - 1) begin m_init = 1'b0; m_cnt = 0; end
            else m_cnt++;
         end
      end
      m_we = e_we; m_addr = e_addr; m_wdata = e_wd;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
   endtask

   // Idles until busy drops (bounded); n = busy cycles observed.
   task automatic wait_sweep(output int n);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         idle();
         if (!g_busy) break;
         n++;
      end
      if (g_busy) begin
         checks++;
         errors++;
         $error("FAIL sweep_timeout observed=busy expected=idle");
      end
   endtask

   initial begin
      int    n;
      string exp_seq;
      logic [255:0] pat;
      for (int s = 0; s < 2; s++)
         for (int l = 0; l < LINES; l++)
            gold[s][l] = '0;
      rst = 1'b1; flush = 1'b0; lk_valid = 1'b0; lk_addr = '0;
      rf_valid = 1'b0; rf_addr = '0; rf_set = '0; rf_data = '0;

      // Reset, then full sweep of 128 lines
      repeat (3) step(1'b1, 1'b0, 1'b1, 7'd3, 1'b1, 7'd4, 1'b1, '1);
      wait_sweep(n);
      chk("sweep_len", 32'(n), 32'd128);
      chk("ready_after_sweep", {g_lkrdy, g_rfrdy}, 2'b11);

      // Refill then lookup of the same line
      pat = {32{8'hA5}};
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 7'd5, 1'b1, pat);
      step(1'b0, 1'b0, 1'b1, 7'd5, 1'b0, '0, 1'b0, '0);
      idle();
      chk("wr_rd_rvalid", g_rvalid, 1'b1);
      chk("wr_rd_set1", g_rdata[511:256], pat);
      chk("wr_rd_set0", g_rdata[255:0], 256'd0);

      // Both valid continuously: four refills then one lookup, repeating
      exp_seq = "RRRRLRRRRLRRRRL";
      for (int i = 0; i < 15; i++) begin
         step(1'b0, 1'b0, 1'b1, 7'(i), 1'b1, 7'(i + 20), i[0], {8{$urandom()}});
         chk("arb_seq", g_win, exp_seq[i]);
      end
      idle();

      // Back-to-back lookups
      for (int i = 0; i < 6; i++)
         step(1'b0, 1'b0, 1'b1, 7'(20 + i), 1'b0, '0, 1'b0, '0);
      idle();
      idle();

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 49) == 0,
              $urandom_range(0, 3) != 0, 7'($urandom_range(0, 7)),
              $urandom_range(0, 3) != 0, 7'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), {8{$urandom()}});
      end
      wait_sweep(n);

      // Flush at sweep counter 60 restarts the sweep
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      for (int i = 0; i < 60; i++) idle();
      chk("model_cnt_60", 32'(m_cnt), 32'd60);
      step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      wait_sweep(n);
      chk("flush_sweep_len", 32'(n), 32'd128);

      // Reset the cycle after a lookup grant suppresses the response
      step(1'b0, 1'b0, 1'b1, 7'd9, 1'b0, '0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      chk("rst_kills_rvalid", g_rvalid, 1'b0);
      idle();
      chk("rst_enters_init", g_busy, 1'b1);
      chk("rst_no_late_rvalid", g_rvalid, 1'b0);
      wait_sweep(n);
      chk("sweep_len_final", 32'(n), 32'd127);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
